// File: rtl/rx_capture_fifo.sv
// rx_capture_fifo
//
// Capture buffer between the UART receiver and its consumers (seven-segment
// display path, command parser). The receiver's level-style write strobe is
// turned into one push per low-to-high transition. Pushed words go into a
// DEPTH-entry show-ahead FIFO. When the FIFO is full, the full-policy either
// drops the new word or overwrites the oldest one. A sticky flag records that
// a push arrived while full. A separate register keeps the last captured word
// for the display, whether or not it has been popped.
//
// Parameters
//   WIDTH      data word width in bits
//   DEPTH      number of FIFO entries (power of two, >= 2)
//   OVERWRITE  full-policy: 0 = drop incoming word, 1 = overwrite oldest
//
// Ports
//   clk         system clock, all logic on the rising edge
//   rst         asynchronous active-low reset
//   i_wr        receiver write strobe (level, may stay high for many cycles)
//   i_data      receiver data, valid while i_wr is high
//   i_rd        pop request from the consumer
//   i_clr_ovf   clears o_overflow
//   o_data      head of the FIFO (show-ahead), meaningless while o_empty
//   o_empty     FIFO holds no words
//   o_full      FIFO holds DEPTH words
//   o_count     number of stored words
//   o_overflow  sticky: a push arrived while the FIFO was full
//   o_last      most recent captured word, independent of pops

module rx_capture_fifo #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 16,
  parameter bit          OVERWRITE = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_wr,
  input  logic [WIDTH-1:0]       i_data,
  input  logic                   i_rd,
  input  logic                   i_clr_ovf,
  output logic [WIDTH-1:0]       o_data,
  output logic                   o_empty,
  output logic                   o_full,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_overflow,
  output logic [WIDTH-1:0]       o_last
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  // State registers
  logic             wr_q;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             ovf_q,    ovf_d;
  logic [WIDTH-1:0] last_q,   last_d;

  logic [WIDTH-1:0] mem [DEPTH];

  // Decoded status, all from count
  logic empty;
  logic full;

  // Per-cycle events
  logic push;   // rising edge of the write strobe
  logic pop;    // accepted read
  logic store;  // word is written into memory this cycle
  logic evict;  // overwrite policy pushes out the oldest word
  logic ovf_set;

  assign empty = (count_q == '0);
  assign full  = (count_q == DEPTH_C);

  // wr_q resets to 1, so a strobe that is already high when reset releases
  // is not seen as a rising edge.
  assign push = i_wr & ~wr_q;
  assign pop  = i_rd & ~empty;

  // A simultaneous pop frees a slot, so a full FIFO can still accept the word.
  // With the overwrite policy the word is stored even without a pop.
  assign store   = push & (~full | pop | OVERWRITE);
  assign evict   = push & full & ~pop & OVERWRITE;
  assign ovf_set = push & full & ~pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    last_d   = last_q;

    if (store) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end

    // The read pointer also moves on an eviction, so the head becomes the
    // next-oldest word.
    if (pop || evict) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    // An eviction stores one word and loses one, so the count does not change.
    // Push+pop while not empty does not change the count either.
    unique case ({store & ~evict, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Setting takes priority over the clear request.
    if (ovf_set) begin
      ovf_d = 1'b1;
    end else if (i_clr_ovf) begin
      ovf_d = 1'b0;
    end

    if (push) begin
      last_d = i_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      last_q   <= '0;
    end else begin
      wr_q     <= i_wr;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      last_q   <= last_d;
    end
  end

  // Storage array. It has no reset, and stale contents are never shown
  // because o_data is only meaningful when the FIFO is not empty.
  always_ff @(posedge clk) begin
    if (store) begin
      mem[wr_ptr_q] <= i_data;
    end
  end

  assign o_data     = mem[rd_ptr_q];
  assign o_empty    = empty;
  assign o_full     = full;
  assign o_count    = count_q;
  assign o_overflow = ovf_q;
  assign o_last     = last_q;

endmodule

// File: tb/tb_rx_capture_fifo.sv
// Testbench for rx_capture_fifo. Two instances share all inputs: one uses the
// drop policy and the other uses the overwrite policy. The reference model
// keeps one queue of words per policy.

module tb_rx_capture_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       i_wr = 1'b0;
  logic       i_rd = 1'b0;
  logic       i_clr_ovf = 1'b0;
  logic [7:0] i_data = 8'h00;

  logic [7:0] d0_data, d1_data, d0_last, d1_last;
  logic       d0_empty, d1_empty, d0_full, d1_full, d0_ovf, d1_ovf;
  logic [4:0] d0_count, d1_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rx_capture_fifo #(.WIDTH(8), .DEPTH(16), .OVERWRITE(1'b0)) u_drop (
    .clk(clk), .rst(rst), .i_wr(i_wr), .i_data(i_data), .i_rd(i_rd),
    .i_clr_ovf(i_clr_ovf), .o_data(d0_data), .o_empty(d0_empty),
    .o_full(d0_full), .o_count(d0_count), .o_overflow(d0_ovf), .o_last(d0_last)
  );

  rx_capture_fifo #(.WIDTH(8), .DEPTH(16), .OVERWRITE(1'b1)) u_ovw (
    .clk(clk), .rst(rst), .i_wr(i_wr), .i_data(i_data), .i_rd(i_rd),
    .i_clr_ovf(i_clr_ovf), .o_data(d1_data), .o_empty(d1_empty),
    .o_full(d1_full), .o_count(d1_count), .o_overflow(d1_ovf), .o_last(d1_last)
  );

  // Reference model state
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  bit         m_ovf0, m_ovf1;
  logic [7:0] m_last;
  bit         m_prev;

  task automatic model_reset();
    q0.delete();
    q1.delete();
    m_ovf0 = 1'b0;
    m_ovf1 = 1'b0;
    m_last = 8'h00;
    m_prev = 1'b1;
  endtask

  // Applies one rising clock edge to the model, using the current inputs.
  task automatic model_edge();
    bit push, full0, full1, pop0, pop1;
    if (!rst) begin
      model_reset();
      return;
    end
    push   = i_wr && !m_prev;
    m_prev = i_wr;
    if (push) m_last = i_data;

    full0 = (q0.size() == 16);
    pop0  = i_rd && (q0.size() != 0);
    if (pop0) void'(q0.pop_front());
    if (push && (!full0 || pop0)) q0.push_back(i_data);
    if (push && full0 && !pop0) m_ovf0 = 1'b1;
    else if (i_clr_ovf)         m_ovf0 = 1'b0;

    full1 = (q1.size() == 16);
    pop1  = i_rd && (q1.size() != 0);
    if (pop1) void'(q1.pop_front());
    if (push) begin
      if (full1 && !pop1) void'(q1.pop_front());
      q1.push_back(i_data);
    end
    if (push && full1 && !pop1) m_ovf1 = 1'b1;
    else if (i_clr_ovf)         m_ovf1 = 1'b0;
  endtask

  // One clock cycle. Inputs change on the falling edge, and outputs are
  // observed there.
  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    model_reset();
    i_wr = 1'b0;
    i_rd = 1'b0;
    i_clr_ovf = 1'b0;
    cyc();
    rst = 1'b1;
    cyc();
  endtask

  task automatic push_word(input logic [7:0] d);
    i_data = d;
    i_wr = 1'b1;
    cyc();
    i_wr = 1'b0;
    cyc();
    $display("push %02h -> count drop=%0d ovw=%0d", d, d0_count, d1_count);
  endtask

  task automatic test_reset();
    i_wr = 1'b1;
    i_data = 8'hA5;
    #1 rst = 1'b0;
    #1 model_reset();
    checks++; if (d0_empty !== 1'b1 || d1_empty !== 1'b1) begin errors++;
      $display("FAIL rst_async_empty got %b/%b exp 1", d0_empty, d1_empty); end
    checks++; if (d0_count !== 5'd0 || d1_count !== 5'd0) begin errors++;
      $display("FAIL rst_async_count got %0d/%0d exp 0", d0_count, d1_count); end
    repeat (3) cyc();
    checks++; if (d0_last !== 8'h00 || d1_last !== 8'h00 || d0_ovf !== 1'b0 || d1_ovf !== 1'b0
                  || d0_full !== 1'b0 || d1_full !== 1'b0) begin errors++;
      $display("FAIL rst_state last %02h/%02h ovf %b/%b full %b/%b exp 00 0 0",
               d0_last, d1_last, d0_ovf, d1_ovf, d0_full, d1_full); end
    rst = 1'b1;
    repeat (2) cyc();
    checks++; if (d0_empty !== 1'b1 || d0_last !== 8'h00 || d1_empty !== 1'b1) begin errors++;
      $display("FAIL rst_held_strobe empty %b/%b last %02h exp 1 00", d0_empty, d1_empty, d0_last); end
    i_wr = 1'b0;
    cyc();
    i_wr = 1'b1;
    cyc();
    checks++; if (d0_count !== 5'd1 || d1_count !== 5'd1) begin errors++;
      $display("FAIL rst_edge_count got %0d/%0d exp 1", d0_count, d1_count); end
    checks++; if (d0_data !== 8'hA5 || d1_data !== 8'hA5 || d0_last !== 8'hA5) begin errors++;
      $display("FAIL rst_edge_data got %02h/%02h last %02h exp a5", d0_data, d1_data, d0_last); end
    i_wr = 1'b0;
    cyc();
    $display("test_reset done");
  endtask

  task automatic test_long_strobe();
    do_reset();
    i_data = 8'h3C;
    i_wr = 1'b1;
    repeat (10) cyc();
    i_wr = 1'b0;
    cyc();
    checks++; if (d0_count !== 5'd1 || d1_count !== 5'd1) begin errors++;
      $display("FAIL long_strobe_count got %0d/%0d exp 1", d0_count, d1_count); end
    checks++; if (d0_data !== 8'h3C || d1_data !== 8'h3C) begin errors++;
      $display("FAIL long_strobe_data got %02h/%02h exp 3c", d0_data, d1_data); end
    $display("test_long_strobe done");
  endtask

  task automatic test_fill_drain();
    do_reset();
    for (int k = 0; k < 16; k++) push_word(8'(k));
    checks++; if (d0_full !== 1'b1 || d1_full !== 1'b1 || d0_count !== 5'd16 || d1_count !== 5'd16) begin
      errors++; $display("FAIL fill_full full %b/%b count %0d/%0d exp 1 16", d0_full, d1_full, d0_count, d1_count); end
    i_rd = 1'b1;
    for (int k = 0; k < 16; k++) begin
      checks++; if (d0_data !== 8'(k) || d1_data !== 8'(k)) begin errors++;
        $display("FAIL drain_order idx %0d got %02h/%02h exp %02h", k, d0_data, d1_data, 8'(k)); end
      cyc();
      $display("pop %02h", 8'(k));
    end
    i_rd = 1'b0;
    checks++; if (d0_empty !== 1'b1 || d1_empty !== 1'b1) begin errors++;
      $display("FAIL drain_empty got %b/%b exp 1", d0_empty, d1_empty); end
    i_rd = 1'b1;
    repeat (3) cyc();
    i_rd = 1'b0;
    checks++; if (d0_count !== 5'd0 || d1_count !== 5'd0 || d0_empty !== 1'b1 || d0_ovf !== 1'b0) begin
      errors++; $display("FAIL rd_empty_ignored count %0d/%0d empty %b ovf %b exp 0 1 0",
                         d0_count, d1_count, d0_empty, d0_ovf); end
    $display("test_fill_drain done");
  endtask

  task automatic test_full_policy();
    logic [7:0] exp1;
    do_reset();
    for (int k = 0; k < 16; k++) push_word(8'(k));
    push_word(8'hEE);
    checks++; if (d0_ovf !== 1'b1 || d0_count !== 5'd16 || d0_data !== 8'h00 || d0_last !== 8'hEE) begin
      errors++; $display("FAIL drop_policy ovf %b count %0d head %02h last %02h exp 1 16 00 ee",
                         d0_ovf, d0_count, d0_data, d0_last); end
    checks++; if (d1_ovf !== 1'b1 || d1_count !== 5'd16 || d1_data !== 8'h01 || d1_last !== 8'hEE) begin
      errors++; $display("FAIL ovw_policy ovf %b count %0d head %02h last %02h exp 1 16 01 ee",
                         d1_ovf, d1_count, d1_data, d1_last); end
    i_clr_ovf = 1'b1;
    cyc();
    i_clr_ovf = 1'b0;
    checks++; if (d0_ovf !== 1'b0 || d1_ovf !== 1'b0) begin errors++;
      $display("FAIL clr_ovf got %b/%b exp 0", d0_ovf, d1_ovf); end
    i_rd = 1'b1;
    for (int k = 0; k < 16; k++) begin
      exp1 = (k < 15) ? 8'(k + 1) : 8'hEE;
      checks++; if (d0_data !== 8'(k) || d1_data !== exp1) begin errors++;
        $display("FAIL policy_drain idx %0d got %02h/%02h exp %02h/%02h", k, d0_data, d1_data, 8'(k), exp1); end
      cyc();
    end
    i_rd = 1'b0;
    checks++; if (d0_empty !== 1'b1 || d1_empty !== 1'b1) begin errors++;
      $display("FAIL policy_drain_empty got %b/%b exp 1", d0_empty, d1_empty); end
    $display("test_full_policy done");
  endtask

  task automatic test_simultaneous();
    do_reset();
    for (int k = 0; k < 16; k++) push_word(8'(k));
    i_data = 8'h55;
    i_wr = 1'b1;
    i_rd = 1'b1;
    cyc();
    i_wr = 1'b0;
    i_rd = 1'b0;
    checks++; if (d0_ovf !== 1'b0 || d1_ovf !== 1'b0 || d0_count !== 5'd16 || d1_count !== 5'd16) begin
      errors++; $display("FAIL full_push_pop ovf %b/%b count %0d/%0d exp 0 16", d0_ovf, d1_ovf, d0_count, d1_count); end
    checks++; if (d0_data !== 8'h01 || d1_data !== 8'h01) begin errors++;
      $display("FAIL full_push_pop_head got %02h/%02h exp 01", d0_data, d1_data); end
    $display("push+pop when full done");

    do_reset();
    i_data = 8'h77;
    i_wr = 1'b1;
    i_rd = 1'b1;
    cyc();
    i_wr = 1'b0;
    i_rd = 1'b0;
    checks++; if (d0_count !== 5'd1 || d1_count !== 5'd1 || d0_data !== 8'h77 || d1_data !== 8'h77) begin
      errors++; $display("FAIL empty_push_pop count %0d/%0d data %02h/%02h exp 1 77",
                         d0_count, d1_count, d0_data, d1_data); end
    $display("push+pop when empty done");

    do_reset();
    for (int k = 0; k < 5; k++) push_word(8'(8'h40 + k));
    checks++; if (d0_count !== 5'd5 || d1_count !== 5'd5) begin errors++;
      $display("FAIL pre_reset_count got %0d/%0d exp 5", d0_count, d1_count); end
    #2 rst = 1'b0;
    #1;
    checks++; if (d0_empty !== 1'b1 || d1_empty !== 1'b1 || d0_count !== 5'd0 || d1_count !== 5'd0) begin
      errors++; $display("FAIL midop_reset empty %b/%b count %0d/%0d exp 1 0",
                         d0_empty, d1_empty, d0_count, d1_count); end
    model_reset();
    cyc();
    rst = 1'b1;
    cyc();
    $display("reset mid-operation done");
  endtask

  task automatic test_random();
    int rd_pct;
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      rd_pct    = (n < 1000) ? 10 : 40;
      i_wr      = ($urandom_range(0, 99) < 50);
      i_rd      = ($urandom_range(0, 99) < rd_pct);
      i_clr_ovf = ($urandom_range(0, 99) < 4);
      i_data    = 8'($urandom);
      cyc();
      checks++; if (d0_count !== 5'(q0.size()) || d1_count !== 5'(q1.size())) begin errors++;
        $display("FAIL rand_count cyc %0d got %0d/%0d exp %0d/%0d", n, d0_count, d1_count, q0.size(), q1.size()); end
      checks++; if (d0_empty !== (q0.size() == 0) || d1_empty !== (q1.size() == 0)
                    || d0_full !== (q0.size() == 16) || d1_full !== (q1.size() == 16)) begin errors++;
        $display("FAIL rand_flags cyc %0d empty %b/%b full %b/%b", n, d0_empty, d1_empty, d0_full, d1_full); end
      checks++; if (d0_ovf !== m_ovf0 || d1_ovf !== m_ovf1) begin errors++;
        $display("FAIL rand_ovf cyc %0d got %b/%b exp %b/%b", n, d0_ovf, d1_ovf, m_ovf0, m_ovf1); end
      checks++; if (d0_last !== m_last || d1_last !== m_last) begin errors++;
        $display("FAIL rand_last cyc %0d got %02h/%02h exp %02h", n, d0_last, d1_last, m_last); end
      if (q0.size() != 0) begin
        checks++; if (d0_data !== q0[0]) begin errors++;
          $display("FAIL rand_head_drop cyc %0d got %02h exp %02h", n, d0_data, q0[0]); end
      end
      if (q1.size() != 0) begin
        checks++; if (d1_data !== q1[0]) begin errors++;
          $display("FAIL rand_head_ovw cyc %0d got %02h exp %02h", n, d1_data, q1[0]); end
      end
    end
    i_wr = 1'b0;
    i_rd = 1'b0;
    i_clr_ovf = 1'b0;
    $display("test_random done: 2000 cycles");
  endtask

  initial begin
    model_reset();
    test_reset();
    test_long_strobe();
    test_fill_drain();
    test_full_policy();
    test_simultaneous();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
